switch_debouncer: RTL and testbench



---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_bit.sv | 88 ++++++++
 rtl/switch_debouncer.sv | 61 ++++++
 tb/tb_switch_debouncer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// The top-level event counter is built only when SWITCH_DEBOUNCER_EVT_CNT_EN is defined.
package debounce_pkg;

    typedef enum logic {ST_STABLE, ST_PENDING} deb_state_t;

    localparam int DEB_DEFAULT_STABLE_CNT = 250000;
    localparam int DEB_EVT_CNT_W          = 8;

    // Counter only has to reach STABLE_CNT-1; keep at least one bit for STABLE_CNT==1.
    function automatic int deb_cnt_w(input int stable_cnt);
        return (stable_cnt > 1) ? $clog2(stable_cnt) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchronizer, stability counter and accept FSM.
// flip_po is high during the cycle whose closing edge updates clean_po.
//
//   state      | meaning
//   ST_STABLE  | synchronized input agrees with clean_po (or STABLE_CNT==1)
//   ST_PENDING | input differs from clean_po, counting consecutive mismatch cycles
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEB_DEFAULT_STABLE_CNT
) (
    input  logic clk_pi,
    input  logic rst_pi,
    input  logic raw_pi,
    output logic clean_po,
    output logic flip_po
);

    localparam int               CNT_W    = deb_cnt_w(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam bit               SINGLE   = (STABLE_CNT == 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_clean;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clean_nxt;
    logic             w_flip;
    logic             w_mismatch;

    assign w_mismatch = r_sync2 ^ r_clean;

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_clean <= 1'b0;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_pi;
            r_sync2 <= r_sync1;
            r_clean <= w_clean_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_clean_nxt = r_clean;
        w_flip      = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_mismatch) begin
                    if (SINGLE) begin
                        w_clean_nxt = r_sync2;
                        w_flip      = 1'b1;
                    end else begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_PENDING: begin
                if (!w_mismatch) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_clean_nxt = r_sync2;
                    w_flip      = 1'b1;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_STABLE;
        endcase
    end

    assign clean_po = r_clean;
    assign flip_po  = w_flip;

endmodule

// File: rtl/switch_debouncer.sv
// N-bit switch debouncer with a registered change strobe.
// Define SWITCH_DEBOUNCER_EVT_CNT_EN to add the 8-bit evt_cnt_po change counter.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int N_BITS     = 4,
    parameter int STABLE_CNT = DEB_DEFAULT_STABLE_CNT
) (
    input  logic                     clk_pi,
    input  logic                     rst_pi,
    input  logic [N_BITS-1:0]        raw_sw_pi,
    output logic [N_BITS-1:0]        clean_sw_po,
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
    output logic                     changed_po,
    output logic [DEB_EVT_CNT_W-1:0] evt_cnt_po
`else
    output logic                     changed_po
`endif
);

    logic [N_BITS-1:0] w_flip;
    logic              r_changed;

    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_bit
        debounce_bit #(
            .STABLE_CNT(STABLE_CNT)
        ) u_bit (
            .clk_pi  (clk_pi),
            .rst_pi  (rst_pi),
            .raw_pi  (raw_sw_pi[gi]),
            .clean_po(clean_sw_po[gi]),
            .flip_po (w_flip[gi])
        );
    end

    // Same-edge flips on several bits collapse into a single strobe.
    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_flip;
        end
    end

    assign changed_po = r_changed;

`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
    logic [DEB_EVT_CNT_W-1:0] r_evt_cnt;

    always_ff @(posedge clk_pi) begin
        if (rst_pi) begin
            r_evt_cnt <= '0;
        end else if (|w_flip) begin
            r_evt_cnt <= r_evt_cnt + DEB_EVT_CNT_W'(1);
        end
    end

    assign evt_cnt_po = r_evt_cnt;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer (N_BITS=4, STABLE_CNT=4) with a run-length reference model.
// Honours SWITCH_DEBOUNCER_EVT_CNT_EN for the event counter port.
module tb_switch_debouncer;

    localparam int N_BITS     = 4;
    localparam int STABLE_CNT = 4;
    localparam int LAT        = STABLE_CNT + 2;

    logic              clk_pi = 1'b0;
    logic              rst_pi;
    logic [N_BITS-1:0] raw_sw_pi;
    logic [N_BITS-1:0] clean_sw_po;
    logic              changed_po;
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
    logic [7:0]        evt_cnt_po;
    logic [7:0]        m_evt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: values seen by the synchronizer, accepted level, mismatch run lengths.
    logic [N_BITS-1:0] m_s1, m_s2, m_clean;
    logic              m_changed;
    int                m_run [N_BITS];

    switch_debouncer #(
        .N_BITS    (N_BITS),
        .STABLE_CNT(STABLE_CNT)
    ) dut (
        .clk_pi     (clk_pi),
        .rst_pi     (rst_pi),
        .raw_sw_pi  (raw_sw_pi),
        .clean_sw_po(clean_sw_po),
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
        .changed_po (changed_po),
        .evt_cnt_po (evt_cnt_po)
`else
        .changed_po (changed_po)
`endif
    );

    always #10 clk_pi = ~clk_pi;

    // Advance the model by one edge using the inputs the DUT is about to sample, then clock.
    task automatic tick();
        logic [N_BITS-1:0] flips;
        flips = '0;
        if (rst_pi) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_changed = 1'b0;
            for (int b = 0; b < N_BITS; b++) m_run[b] = 0;
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
            m_evt = '0;
`endif
        end else begin
            for (int b = 0; b < N_BITS; b++) begin
                if (m_s2[b] != m_clean[b]) begin
                    m_run[b]++;
                    if (m_run[b] == STABLE_CNT) begin
                        flips[b] = 1'b1;
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_clean   = m_clean ^ flips;
            m_changed = |flips;
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
            if (m_changed) m_evt = m_evt + 8'd1;
`endif
            m_s2 = m_s1;
            m_s1 = raw_sw_pi;
        end
        @(posedge clk_pi);
        #1;
    endtask

    task automatic apply_reset();
        raw_sw_pi = '0;
        rst_pi    = 1'b1;
        tick();
        tick();
        rst_pi    = 1'b0;
    endtask

    task automatic test_reset();
        int pulses = 0;
        int hit    = 0;
        raw_sw_pi = 4'b1111;
        rst_pi    = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks += 2;
            if (clean_sw_po !== 4'b0000) begin
                failures++; $display("FAIL reset_clean: got %b exp 0000", clean_sw_po);
            end
            if (changed_po !== 1'b0) begin
                failures++; $display("FAIL reset_changed: got %b exp 0", changed_po);
            end
        end
        rst_pi = 1'b0;
        for (int e = 1; e <= LAT + 4; e++) begin
            tick();
            if (changed_po === 1'b1) pulses++;
            if (hit == 0 && clean_sw_po === 4'b1111) hit = e;
            checks++;
            if (clean_sw_po !== m_clean) begin
                failures++; $display("FAIL reset_release_model: got %b exp %b", clean_sw_po, m_clean);
            end
        end
        checks += 2;
        if (hit != LAT) begin
            failures++; $display("FAIL reset_release_latency: got edge %0d exp %0d", hit, LAT);
        end
        if (pulses != 1) begin
            failures++; $display("FAIL reset_release_pulses: got %0d exp 1", pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        apply_reset();
        raw_sw_pi = 4'b0101;
        for (int e = 0; e < 3; e++) begin
            tick();
            if (changed_po === 1'b1) pulses++;
        end
        raw_sw_pi = 4'b0000;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (changed_po === 1'b1) pulses++;
            checks++;
            if (clean_sw_po !== 4'b0000) begin
                failures++; $display("FAIL glitch_clean: got %b exp 0000", clean_sw_po);
            end
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("FAIL glitch_pulses: got %0d exp 0", pulses);
        end
    endtask

    task automatic test_accept();
        int pulses = 0;
        int hit    = 0;
        apply_reset();
        raw_sw_pi = 4'b0011;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (changed_po === 1'b1) pulses++;
            if (hit == 0 && clean_sw_po === 4'b0011) hit = e;
            checks += 2;
            if (clean_sw_po !== m_clean) begin
                failures++; $display("FAIL accept_model_clean: got %b exp %b", clean_sw_po, m_clean);
            end
            if (changed_po !== m_changed) begin
                failures++; $display("FAIL accept_model_changed: got %b exp %b", changed_po, m_changed);
            end
        end
        checks += 3;
        if (hit != LAT) begin
            failures++; $display("FAIL accept_latency: got edge %0d exp %0d", hit, LAT);
        end
        if (pulses != 1) begin
            failures++; $display("FAIL accept_pulses: got %0d exp 1", pulses);
        end
        if (clean_sw_po !== 4'b0011) begin
            failures++; $display("FAIL accept_final: got %b exp 0011", clean_sw_po);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int hit    = 0;
        apply_reset();
        for (int e = 0; e < 8; e++) begin
            raw_sw_pi[0] = ~raw_sw_pi[0];
            tick();
            if (changed_po === 1'b1) pulses++;
            checks++;
            if (clean_sw_po !== 4'b0000) begin
                failures++; $display("FAIL bounce_during: got %b exp 0000", clean_sw_po);
            end
        end
        raw_sw_pi[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (changed_po === 1'b1) pulses++;
            if (hit == 0 && clean_sw_po[0] === 1'b1) hit = e;
        end
        checks += 2;
        if (hit != LAT) begin
            failures++; $display("FAIL bounce_latency: got edge %0d exp %0d", hit, LAT);
        end
        if (pulses != 1) begin
            failures++; $display("FAIL bounce_pulses: got %0d exp 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int p1 = 0;
        int p2 = 0;
        int pulses = 0;
        apply_reset();
        raw_sw_pi[1] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3) raw_sw_pi[2] = 1'b1;
            tick();
            if (changed_po === 1'b1) begin
                pulses++;
                if (p1 == 0) p1 = e;
                else if (p2 == 0) p2 = e;
            end
        end
        checks += 4;
        if (p1 != LAT || p2 != LAT + 2) begin
            failures++; $display("FAIL stagger_pulse_edges: got %0d,%0d exp %0d,%0d", p1, p2, LAT, LAT + 2);
        end
        if (pulses != 2) begin
            failures++; $display("FAIL stagger_pulses: got %0d exp 2", pulses);
        end
        if (clean_sw_po !== 4'b0110) begin
            failures++; $display("FAIL stagger_final: got %b exp 0110", clean_sw_po);
        end
        if (clean_sw_po !== m_clean) begin
            failures++; $display("FAIL stagger_model: got %b exp %b", clean_sw_po, m_clean);
        end
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
        checks++;
        if (evt_cnt_po !== 8'd2) begin
            failures++; $display("FAIL stagger_evt: got %0d exp 2", evt_cnt_po);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int hit    = 0;
        apply_reset();
        raw_sw_pi = 4'b1000;
        tick();
        if (changed_po === 1'b1) pulses++;
        tick();
        if (changed_po === 1'b1) pulses++;
        rst_pi = 1'b1;
        tick();
        if (changed_po === 1'b1) pulses++;
        rst_pi = 1'b0;
        checks += 2;
        if (pulses != 0) begin
            failures++; $display("FAIL midreset_pulses: got %0d exp 0", pulses);
        end
        if (clean_sw_po !== 4'b0000) begin
            failures++; $display("FAIL midreset_clean: got %b exp 0000", clean_sw_po);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (hit == 0 && clean_sw_po === 4'b1000) hit = e;
        end
        checks++;
        if (hit != LAT) begin
            failures++; $display("FAIL midreset_latency: got edge %0d exp %0d", hit, LAT);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(5, 0) == 0) raw_sw_pi = N_BITS'($urandom);
            rst_pi = ($urandom_range(79, 0) == 0);
            tick();
            checks += 2;
            if (clean_sw_po !== m_clean) begin
                failures++; $display("FAIL random_clean cyc %0d: got %b exp %b", c, clean_sw_po, m_clean);
            end
            if (changed_po !== m_changed) begin
                failures++; $display("FAIL random_changed cyc %0d: got %b exp %b", c, changed_po, m_changed);
            end
`ifdef SWITCH_DEBOUNCER_EVT_CNT_EN
            checks++;
            if (evt_cnt_po !== m_evt) begin
                failures++; $display("FAIL random_evt cyc %0d: got %0d exp %0d", c, evt_cnt_po, m_evt);
            end
`endif
        end
        rst_pi = 1'b0;
    endtask

    initial begin
        rst_pi    = 1'b1;
        raw_sw_pi = '0;
        test_reset();
        test_glitch();
        test_accept();
        test_bounce();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
